// File: rtl/microprog_sequencer.sv
// Control-store sequencer for the X/Y/Z + ULA datapath (load X, load Y, hold, shift Y, store Z).
// Optional MICROPROG_SINGLE_STEP_EN adds step_en to gate advancement through S0-S4.
module microprog_sequencer #(
  parameter int DATA_W = 4,
  parameter int X      = 4,
  parameter int Y      = 2,
  parameter int SHIFTS = 1,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MICROPROG_SINGLE_STEP_EN
  input  logic              step_en,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  contagem,
  output logic [1:0]        ctrl_x,
  output logic [1:0]        ctrl_y,
  output logic [1:0]        ctrl_z,
  output logic              ula_op,
  output logic [DATA_W-1:0] valor
);

  localparam int SH_N = (SHIFTS < 1) ? 1 : SHIFTS;
  localparam int SC_W = (SH_N < 2) ? 1 : $clog2(SH_N + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SH_N - 1);
  localparam logic [DATA_W-1:0] X_V = DATA_W'(X);
  localparam logic [DATA_W-1:0] Y_V = DATA_W'(Y);

  typedef enum logic [2:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    S4,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SC_W-1:0] sc;
  logic [SC_W-1:0] sc_nx;
  logic            adv;
  logic [2:0]      step;

`ifdef MICROPROG_SINGLE_STEP_EN
  assign adv = step_en;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sc    <= '0;
    end else begin
      state <= state_nx;
      sc    <= sc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sc_nx    = sc;
    unique case (state)
      IDLE: if (start) state_nx = S0;
      S0:   if (adv) state_nx = S1;
      S1:   if (adv) state_nx = S2;
      S2: begin
        if (adv) begin
          state_nx = S3;
          sc_nx    = '0;
        end
      end
      S3: begin
        // sc stops at SC_LAST, so it never wraps while shifting
        if (adv) begin
          if (sc == SC_LAST) state_nx = S4;
          else               sc_nx    = sc + 1'b1;
        end
      end
      S4:   if (adv) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    step   = 3'd0;
    ctrl_x = 2'b00;
    ctrl_y = 2'b00;
    ctrl_z = 2'b00;
    ula_op = 1'b0;
    valor  = '0;
    unique case (state)
      S0: begin
        busy   = 1'b1;
        ctrl_x = 2'b01;
        ctrl_y = 2'b10;
        ctrl_z = 2'b10;
        valor  = X_V;
      end
      S1: begin
        busy   = 1'b1;
        step   = 3'd1;
        ctrl_x = 2'b01;
        ctrl_y = 2'b01;
        valor  = Y_V;
      end
      S2: begin
        busy   = 1'b1;
        step   = 3'd2;
        ctrl_y = 2'b01;
      end
      S3: begin
        busy   = 1'b1;
        step   = 3'd3;
        ctrl_y = 2'b11;
      end
      S4: begin
        busy   = 1'b1;
        step   = 3'd4;
        ctrl_x = 2'b10;
        ctrl_y = 2'b10;
        ctrl_z = 2'b01;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign contagem = CNT_W'(step);

endmodule

// File: tb/tb_microprog_sequencer.sv
// Directed bench for microprog_sequencer: vector table plus shift, hold-start
// and single-step sequences across several parameter sets.
module tb_microprog_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic step_en = 1'b1;

  always #5 clk = ~clk;

  logic       a_busy, a_done, a_ula;
  logic [3:0] a_cnt, a_val;
  logic [1:0] a_x, a_y, a_z;

  logic       t_busy, t_done, t_ula;
  logic [3:0] t_cnt, t_val;
  logic [1:0] t_x, t_y, t_z;

  logic       z_busy, z_done, z_ula;
  logic [3:0] z_cnt, z_val;
  logic [1:0] z_x, z_y, z_z;

  logic       n_busy, n_done, n_ula;
  logic [3:0] n_cnt;
  logic [1:0] n_val;
  logic [1:0] n_x, n_y, n_z;

  microprog_sequencer u0 (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef MICROPROG_SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .busy(a_busy), .done(a_done), .contagem(a_cnt),
    .ctrl_x(a_x), .ctrl_y(a_y), .ctrl_z(a_z),
    .ula_op(a_ula), .valor(a_val)
  );

  microprog_sequencer #(.SHIFTS(3)) u3 (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef MICROPROG_SINGLE_STEP_EN
    .step_en(1'b1),
`endif
    .busy(t_busy), .done(t_done), .contagem(t_cnt),
    .ctrl_x(t_x), .ctrl_y(t_y), .ctrl_z(t_z),
    .ula_op(t_ula), .valor(t_val)
  );

  microprog_sequencer #(.SHIFTS(0)) uz (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef MICROPROG_SINGLE_STEP_EN
    .step_en(1'b1),
`endif
    .busy(z_busy), .done(z_done), .contagem(z_cnt),
    .ctrl_x(z_x), .ctrl_y(z_y), .ctrl_z(z_z),
    .ula_op(z_ula), .valor(z_val)
  );

  microprog_sequencer #(.DATA_W(2), .X(4), .Y(2)) u2 (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef MICROPROG_SINGLE_STEP_EN
    .step_en(1'b1),
`endif
    .busy(n_busy), .done(n_done), .contagem(n_cnt),
    .ctrl_x(n_x), .ctrl_y(n_y), .ctrl_z(n_z),
    .ula_op(n_ula), .valor(n_val)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int rst;
    int st;
    int busy;
    int done;
    int cnt;
    int x;
    int y;
    int z;
    int val;
  } vec_t;

  vec_t tv[18];

  initial begin
    int y3_t, y3_z, bad_t, dk_t, dk_z, dcnt;
    logic [9:0] bh, dh;

    //          rst st busy done cnt x  y  z  val
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 1, 1, 0, 0, 1, 2, 2, 4};
    tv[4]  = '{0, 1, 1, 0, 1, 1, 1, 0, 2};
    tv[5]  = '{0, 0, 1, 0, 2, 0, 1, 0, 0};
    tv[6]  = '{0, 0, 1, 0, 3, 0, 3, 0, 0};
    tv[7]  = '{0, 0, 1, 0, 4, 2, 2, 1, 0};
    tv[8]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tv[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[10] = '{0, 1, 1, 0, 0, 1, 2, 2, 4};
    tv[11] = '{0, 0, 1, 0, 1, 1, 1, 0, 2};
    tv[12] = '{0, 0, 1, 0, 2, 0, 1, 0, 0};
    tv[13] = '{0, 0, 1, 0, 3, 0, 3, 0, 0};
    tv[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst     = tv[i].rst[0];
      start_a = tv[i].st[0];
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", i), int'(a_busy), tv[i].busy);
      check($sformatf("v%0d_done", i), int'(a_done), tv[i].done);
      check($sformatf("v%0d_cnt", i), int'(a_cnt), tv[i].cnt);
      check($sformatf("v%0d_x", i), int'(a_x), tv[i].x);
      check($sformatf("v%0d_y", i), int'(a_y), tv[i].y);
      check($sformatf("v%0d_z", i), int'(a_z), tv[i].z);
      check($sformatf("v%0d_val", i), int'(a_val), tv[i].val);
      check($sformatf("v%0d_ula", i), int'(a_ula), 0);
    end

    // SHIFTS=3, SHIFTS=0 and DATA_W=2 instances started together
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    check("trunc_s0_val", int'(n_val), 0);
    check("trunc_s0_cnt", int'(n_cnt), 0);
    @(negedge clk);
    start_b = 1'b0;
    y3_t = 0; y3_z = 0; bad_t = 0; dk_t = -1; dk_z = -1;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("trunc_s1_val", int'(n_val), 2);
      if (t_y == 2'b11) begin
        y3_t++;
        if (t_cnt != 4'd3) bad_t++;
      end
      if (z_y == 2'b11) y3_z++;
      if (t_done && dk_t < 0) dk_t = k;
      if (z_done && dk_z < 0) dk_z = k;
    end
    check("sh3_shift_cycles", y3_t, 3);
    check("sh3_cnt_bad", bad_t, 0);
    check("sh3_done_edge", dk_t, 7);
    check("sh0_shift_cycles", y3_z, 1);
    check("sh0_done_edge", dk_z, 5);
    check("sh3_idle_busy", int'(t_busy), 0);

    // start held for 10 edges
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bh[i] = a_busy;
      dh[i] = a_done;
    end
    @(negedge clk);
    start_a = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (a_done) dcnt++;
    end
    check("hold_busy_trace", int'(bh), int'(10'b1110011111));
    check("hold_done_trace", int'(dh), int'(10'b0000100000));
    check("hold_second_done", dcnt, 1);
    check("hold_end_busy", int'(a_busy), 0);

`ifdef MICROPROG_SINGLE_STEP_EN
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    #1;
    check("ss_s1_cnt", int'(a_cnt), 1);
    @(negedge clk);
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ss_hold%0d_cnt", i), int'(a_cnt), 1);
      check($sformatf("ss_hold%0d_val", i), int'(a_val), 2);
      check($sformatf("ss_hold%0d_y", i), int'(a_y), 1);
    end
    @(negedge clk);
    step_en = 1'b1;
    @(posedge clk);
    #1;
    check("ss_resume_cnt", int'(a_cnt), 2);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (a_done) dcnt++;
    end
    check("ss_done", dcnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/microprog_sequencer.md
Name: microprog_sequencer

Overview:
Parametrised control-store sequencer for the X/Y/Z register + ULA datapath. It runs its own step counter through the fixed 5-step microprogram (load X, load Y, hold, shift Y, store Z) on a start request. Each step drives per-register control fields, a ULA op and an immediate `valor`. The shift step can repeat a parameterised number of times. It sits between the top-level controller (start/done handshake) and the datapath register control inputs.

Parameters:
- DATA_W, 4, width of the `valor` immediate bus.
- X, 4, immediate driven in step 0; truncated to DATA_W.
- Y, 2, immediate driven in step 1; truncated to DATA_W.
- SHIFTS, 1, number of consecutive cycles spent in the shift step. Values below 1 are treated as 1.
- CNT_W, 4, width of the `contagem` step-index output.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a program run; sampled only in IDLE.
- busy  out  1  high while a run is in progress (steps 0-4).
- done  out  1  one-cycle pulse after step 4 completes.
- contagem  out  CNT_W  current step index 0-4; 0 in IDLE/DONE.
- ctrl_x  out  2  X register control: 00 hold, 01 load, 10 clear.
- ctrl_y  out  2  Y register control: 00 hold, 01 load, 10 clear, 11 shift right.
- ctrl_z  out  2  Z register control: 00 hold, 01 load, 10 clear.
- ula_op  out  1  0 = add, 1 = don't care; it is driven as 0 in every step.
- valor  out  DATA_W  immediate for the datapath.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine (Moore): IDLE, S0, S1, S2, S3, S4, DONE. All outputs are a decode of the registered state plus the shift counter.
- Reset values: state IDLE, shift counter 0. Outputs: busy 0, done 0, contagem 0, ctrl_x/ctrl_y/ctrl_z 00, ula_op 0, valor 0.
- IDLE: all control fields 00, valor 0. If start=1 at an edge, go to S0. S0 outputs are valid in the next cycle (1-cycle latency).
- S0: x=01, y=10, z=10, valor=X, contagem=0. Next state S1.
- S1: x=01, y=01, z=00, valor=Y, contagem=1. Next state S2.
- S2: x=00, y=01, z=00, valor=0, contagem=2. Next state S3; clear the shift counter.
- S3: x=00, y=11, z=00, valor=0, contagem=3.
  - Shift counter increments each cycle.
  - Leave to S4 on the edge where counter == SHIFTS-1.
  - The state lasts exactly max(SHIFTS,1) cycles.
- S4: x=10, y=10, z=01, valor=0, contagem=4. Next state DONE.
- DONE: done=1, busy=0, controls 00, contagem 0. Next state IDLE unconditionally. start is ignored in DONE.
- busy is 1 in S0-S4 only. start is ignored while busy; it is not queued.
- Total run time: 5 + max(SHIFTS,1) cycles from the start edge to the done pulse, counting the DONE cycle.
- Reset mid-run: at the next edge go to IDLE with reset outputs. No done pulse.
- rst and start high together: rst wins.
- Shift counter width: $clog2(SHIFTS+1), minimum 1 bit. The counter never wraps inside S3.
- The contagem encoding is zero-extended into CNT_W bits. CNT_W must be at least 3.

Optional Feature:
- Macro: MICROPROG_SINGLE_STEP_EN.
- Defined: adds input port `step_en` (1 bit) after `start`.
  - In S0-S4 the state and shift counter advance only on edges where step_en=1; otherwise everything holds and outputs stay static.
  - IDLE and DONE transitions are unaffected by step_en.
- Undefined: no step_en port; the sequencer advances every cycle as specified above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 with no start → all outputs 0 indefinitely; busy=0, done=0.
- Nominal run (defaults): start pulse at edge 0 → per cycle:
  - S0: contagem 0, valor 4, x=01, y=10, z=10.
  - S1: contagem 1, valor 2, x=01, y=01.
  - S2: contagem 2, y=01.
  - S3: contagem 3, y=11, one cycle.
  - S4: contagem 4, x=10, y=10, z=01.
  - Then done=1 for exactly one cycle, then IDLE.
- Repeated shift: SHIFTS=3, start → y=11 for exactly 3 consecutive cycles, contagem=3 throughout; done 8 cycles after the start edge.
- Start while busy / start held: start held high for 10 cycles → one run only; a second run begins only after DONE, from IDLE. No restart or corruption mid-run.
- Reset mid-run: assert rst during S3 → next cycle IDLE outputs (all 0), no done pulse; a new start afterwards runs the full sequence.
- Truncation, plus single-step (with MICROPROG_SINGLE_STEP_EN):
  - DATA_W=2, X=4, Y=2 → valor 0 in S0 and 2 in S1.
  - With the macro, step_en=0 for 3 cycles in S1 → S1 outputs held 3 extra cycles, then the sequence resumes.
